// File: rtl/fifo_bram_writer_pkg.sv
// Shared widths and constants for the Intan acquisition stream path into BRAM.
// Status field widths match the register block that reads them.
package intan_stream_pkg;
    localparam int          WORD_W              = 64;
    localparam logic [7:0]  BRAM_WE_ALL         = 8'hFF;
    localparam int          BYTES_PER_WORD_LOG2 = 3;
    localparam int          FIFO_COUNT_W        = 9;
    localparam int          BRAM_PTR_W          = 13;

    // Circular-buffer successor of a BRAM word index.
    function automatic logic [BRAM_PTR_W-1:0] next_word_ptr(
        input logic [BRAM_PTR_W-1:0] ptr,
        input int                    depth_words
    );
        if (ptr == BRAM_PTR_W'(depth_words - 1))
            return '0;
        return ptr + 1'b1;
    endfunction
endpackage

// File: rtl/fifo_bram_writer_if.sv
// Write-only BRAM port driven by fifo_bram_writer.
// Handshake: no ready exists; the BRAM accepts a write on every edge where bram_en is high.
interface fifo_bram_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              bram_clk;
    logic              bram_rst;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_en;
    logic [7:0]        bram_we;

    modport master (
        output bram_clk, bram_rst, bram_addr, bram_din, bram_en, bram_we
    );
    modport slave (
        input  bram_clk, bram_rst, bram_addr, bram_din, bram_en, bram_we
    );
endinterface

// File: rtl/fifo_bram_writer_sync_fifo.sv
// Single-clock circular FIFO with show-ahead read: dout always presents the head entry.
// Pushes while full are dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_bram_writer.sv
// Buffers 64-bit acquisition words and drains one per cycle into a circular BRAM region.
// Exposes FIFO occupancy and the next BRAM word index for status readout.
module fifo_bram_writer
    import intan_stream_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH  = 64,
    parameter int BRAM_DEPTH_WORDS = 8192,
    parameter int FIFO_DEPTH       = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_write_en,
    input  logic [WORD_W-1:0]        fifo_write_data,
    output logic                     fifo_full,
    output logic [FIFO_COUNT_W-1:0]  fifo_count,
    output logic [BRAM_PTR_W-1:0]    current_bram_address,
    fifo_bram_writer_if.master       bram
);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WORD_W-1:0]          w_head;
    logic [FIFO_CNT_W-1:0]      w_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;

    logic [BRAM_PTR_W-1:0]      r_wptr;
    logic [BRAM_ADDR_WIDTH-1:0] r_addr;
    logic [WORD_W-1:0]          r_din;
    logic                       r_en;
    logic [7:0]                 r_we;

    // The BRAM never stalls, so anything buffered is drained immediately.
    assign w_pop = !w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_write_en),
        .pop   (w_pop),
        .din   (fifo_write_data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_addr <= '0;
            r_din  <= '0;
            r_en   <= 1'b0;
            r_we   <= '0;
        end else if (w_pop) begin
            r_din  <= w_head;
            r_addr <= BRAM_ADDR_WIDTH'({r_wptr, {BYTES_PER_WORD_LOG2{1'b0}}});
            r_en   <= 1'b1;
            r_we   <= BRAM_WE_ALL;
            r_wptr <= next_word_ptr(r_wptr, BRAM_DEPTH_WORDS);
        end else begin
            r_en   <= 1'b0;
            r_we   <= '0;
        end
    end

    assign fifo_full            = w_full;
    assign fifo_count           = FIFO_COUNT_W'(w_count);
    assign current_bram_address = r_wptr;

    assign bram.bram_clk  = clk;
    assign bram.bram_rst  = rst;
    assign bram.bram_addr = r_addr;
    assign bram.bram_din  = BRAM_DATA_WIDTH'(r_din);
    assign bram.bram_en   = r_en;
    assign bram.bram_we   = r_we;
endmodule

// File: tb/tb_fifo_bram_writer.sv
// Bench for fifo_bram_writer plus a standalone sync_fifo for the full/drop behaviour.
module tb_fifo_bram_writer;
    import intan_stream_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    fifo_write_en = 1'b0;
    logic [63:0]             fifo_write_data = '0;
    logic                    fifo_full;
    logic [8:0]              fifo_count;
    logic [12:0]             current_bram_address;

    logic                    f_push = 1'b0;
    logic                    f_pop = 1'b0;
    logic [63:0]             f_din = '0;
    logic [63:0]             f_dout;
    logic [8:0]              f_count;
    logic                    f_full;
    logic                    f_empty;

    int checks = 0;
    int errors = 0;
    logic [79:0] exp_q[$];
    logic [63:0] fq[$];
    logic [12:0] model_wptr = '0;

    always #5 clk = ~clk;

    fifo_bram_writer_if #(.ADDR_W(16), .DATA_W(64)) bram_if ();

    fifo_bram_writer #(
        .BRAM_ADDR_WIDTH  (16),
        .BRAM_DATA_WIDTH  (64),
        .BRAM_DEPTH_WORDS (8192),
        .FIFO_DEPTH       (256)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fifo_write_en        (fifo_write_en),
        .fifo_write_data      (fifo_write_data),
        .fifo_full            (fifo_full),
        .fifo_count           (fifo_count),
        .current_bram_address (current_bram_address),
        .bram                 (bram_if)
    );

    sync_fifo #(.DEPTH(256), .WIDTH(64)) u_sf (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    // Scoreboard: every BRAM write is matched against the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (bram_if.bram_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h din=%h, no write expected", bram_if.bram_addr, bram_if.bram_din);
            end else begin
                logic [79:0] e;
                e = exp_q.pop_front();
                if ({bram_if.bram_addr, bram_if.bram_din} !== e || bram_if.bram_we !== 8'hFF) begin
                    errors++;
                    $display("FAIL bram_write: got addr=%h din=%h we=%h, want addr=%h din=%h we=ff",
                             bram_if.bram_addr, bram_if.bram_din, bram_if.bram_we, e[79:64], e[63:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [63:0] data);
        exp_q.push_back({model_wptr, 3'b000, data});
        model_wptr = (model_wptr == 13'd8191) ? 13'd0 : model_wptr + 13'd1;
    endtask

    task automatic push_word(input logic [63:0] data);
        fifo_write_en   = 1'b1;
        fifo_write_data = data;
        expect_write(data);
        tick();
        fifo_write_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || bram_if.bram_en !== 1'b0 || fifo_count !== 9'd0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d bram_en=%b count=%0d, want 0/0/0", name, exp_q.size(), bram_if.bram_en, fifo_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_write_en = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        model_wptr = '0;
        checks++;
        if (fifo_count !== 9'd0 || fifo_full !== 1'b0 || bram_if.bram_en !== 1'b0 || bram_if.bram_we !== 8'h00 ||
            current_bram_address !== 13'd0 || bram_if.bram_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: count=%0d full=%b en=%b we=%h cur=%0d addr=%h, want all zero",
                     fifo_count, fifo_full, bram_if.bram_en, bram_if.bram_we, current_bram_address, bram_if.bram_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        fifo_write_en   = 1'b1;
        fifo_write_data = 64'hDEADBEEF_CAFEF00D;
        expect_write(64'hDEADBEEF_CAFEF00D);
        tick();
        fifo_write_en = 1'b0;
        checks++;
        if (fifo_count !== 9'd1 || bram_if.bram_en !== 1'b0) begin
            errors++;
            $display("FAIL single_after_push: count=%0d en=%b, want 1/0", fifo_count, bram_if.bram_en);
        end
        tick();
        checks++;
        if (bram_if.bram_en !== 1'b1 || bram_if.bram_we !== 8'hFF || bram_if.bram_addr !== 16'h0000 ||
            bram_if.bram_din !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL single_write: en=%b we=%h addr=%h din=%h, want 1/ff/0000/deadbeefcafef00d",
                     bram_if.bram_en, bram_if.bram_we, bram_if.bram_addr, bram_if.bram_din);
        end
        checks++;
        if (fifo_count !== 9'd0 || current_bram_address !== 13'd1) begin
            errors++;
            $display("FAIL single_status: count=%0d cur=%0d, want 0/1", fifo_count, current_bram_address);
        end
        tick();
        checks++;
        if (bram_if.bram_en !== 1'b0 || bram_if.bram_we !== 8'h00) begin
            errors++;
            $display("FAIL single_idle: en=%b we=%h, want 0/00", bram_if.bram_en, bram_if.bram_we);
        end
        checks++;
        if (bram_if.bram_addr !== 16'h0000 || bram_if.bram_din !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL single_hold: addr=%h din=%h, want held 0000/deadbeefcafef00d", bram_if.bram_addr, bram_if.bram_din);
        end
    endtask

    task automatic test_burst();
        test_reset();
        for (int i = 0; i < 144; i++)
            push_word(64'(i));
        wait_drain("burst");
        checks++;
        if (current_bram_address !== 13'd144 || bram_if.bram_addr !== 16'd1144) begin
            errors++;
            $display("FAIL burst_end: cur=%0d last_addr=%0d, want 144/1144", current_bram_address, bram_if.bram_addr);
        end
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < 200; i++) begin
            push_word({$urandom, $urandom});
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain("random");
        checks++;
        if (current_bram_address !== 13'd344) begin
            errors++;
            $display("FAIL random_ptr: cur=%0d, want 344", current_bram_address);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i <= 8192; i++)
            push_word(64'(i) ^ 64'hA5A5_0000_0000_0000);
        wait_drain("wrap");
        checks++;
        if (current_bram_address !== 13'd1 || bram_if.bram_addr !== 16'h0000 ||
            bram_if.bram_din !== (64'd8192 ^ 64'hA5A5_0000_0000_0000)) begin
            errors++;
            $display("FAIL wrap_end: cur=%0d addr=%h din=%h, want 1/0000/a5a5000000002000",
                     current_bram_address, bram_if.bram_addr, bram_if.bram_din);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 10; i++)
            push_word(64'h1111_0000_0000_0000 + 64'(i));
        fifo_write_en   = 1'b1;
        fifo_write_data = 64'h2222_2222_2222_2222;
        rst = 1'b1;
        tick();
        exp_q.delete();
        model_wptr = '0;
        checks++;
        if (bram_if.bram_en !== 1'b0 || bram_if.bram_we !== 8'h00 || bram_if.bram_addr !== 16'h0000 ||
            bram_if.bram_din !== 64'h0 || current_bram_address !== 13'd0 || fifo_count !== 9'd0) begin
            errors++;
            $display("FAIL midreset_clear: en=%b we=%h addr=%h din=%h cur=%0d count=%0d, want all zero",
                     bram_if.bram_en, bram_if.bram_we, bram_if.bram_addr, bram_if.bram_din, current_bram_address, fifo_count);
        end
        rst = 1'b0;
        push_word(64'h3333_3333_3333_3333);
        push_word(64'h4444_4444_4444_4444);
        wait_drain("midreset");
        checks++;
        if (current_bram_address !== 13'd2) begin
            errors++;
            $display("FAIL midreset_ptr: cur=%0d, want 2", current_bram_address);
        end
    endtask

    task automatic test_fifo_full_drop();
        test_reset();
        fq.delete();
        for (int i = 0; i < 256; i++) begin
            f_push = 1'b1;
            f_din  = {$urandom, $urandom};
            fq.push_back(f_din);
            tick();
        end
        f_push = 1'b0;
        checks++;
        if (f_full !== 1'b1 || f_count !== 9'd256 || f_empty !== 1'b0) begin
            errors++;
            $display("FAIL fifo_fill: full=%b count=%0d empty=%b, want 1/256/0", f_full, f_count, f_empty);
        end
        f_push = 1'b1;
        f_din  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        f_push = 1'b0;
        checks++;
        if (f_count !== 9'd256 || f_dout !== fq[0]) begin
            errors++;
            $display("FAIL fifo_drop: count=%0d head=%h, want 256/%h", f_count, f_dout, fq[0]);
        end
        // Push+pop while full: the push must still be dropped.
        checks++;
        if (f_dout !== fq[0]) begin
            errors++;
            $display("FAIL fifo_head: got %h, want %h", f_dout, fq[0]);
        end
        void'(fq.pop_front());
        f_push = 1'b1;
        f_pop  = 1'b1;
        f_din  = 64'hBAD1_BAD1_BAD1_BAD1;
        tick();
        f_push = 1'b0;
        checks++;
        if (f_count !== 9'd255 || f_full !== 1'b0) begin
            errors++;
            $display("FAIL fifo_pushpop_full: count=%0d full=%b, want 255/0", f_count, f_full);
        end
        while (fq.size() != 0) begin
            logic [63:0] e;
            e = fq.pop_front();
            checks++;
            if (f_dout !== e) begin
                errors++;
                $display("FAIL fifo_order: got %h, want %h", f_dout, e);
            end
            tick();
        end
        f_pop = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_count !== 9'd0) begin
            errors++;
            $display("FAIL fifo_empty: empty=%b count=%0d, want 1/0", f_empty, f_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_burst();
        test_random_gaps();
        test_reset_midstream();
        test_wrap();
        test_fifo_full_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete within 2 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
